// File: rtl/data_sram_responder_if.sv
// Data-side SRAM request channel between the CPU memory stage and a responder.
// The master drives requests; the slave answers with addr_ok/data_ok/rdata.
interface data_sram_responder_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req,
        output wr,
        output size,
        output wstrb,
        output addr,
        output wdata,
        input  addr_ok,
        input  data_ok,
        input  rdata
    );

    modport slave (
        input  req,
        input  wr,
        input  size,
        input  wstrb,
        input  addr,
        input  wdata,
        output addr_ok,
        output data_ok,
        output rdata
    );
endinterface

// File: rtl/data_sram_responder.sv
// Data SRAM responder: word-addressed RAM behind the CPU data request channel.
// Requests are accepted when a response slot is free, committed to the RAM at
// the accepting edge, and answered in order after a fixed latency of LAT cycles.
// Reads capture the RAM word at acceptance, so later writes never leak into an
// earlier read's response.
module data_sram_responder #(
    parameter int ADDR_W = 12,
    parameter int LAT    = 2,
    parameter int DEPTH  = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    data_sram_responder_if.slave    data_sram,
    input  logic                    stall_in,
    output logic [3:0]              outstanding
);

    // A single-entry queue still needs a one-bit pointer to stay legal.
    localparam int              PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]      CNT_INIT  = 4'(LAT - 1);
    localparam logic [3:0]      DEPTH_CNT = 4'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam int              WORDS     = 2 ** ADDR_W;

    logic [31:0]       mem [WORDS];

    logic [ADDR_W-1:0] word_idx;
    logic              fire;
    logic              pop;

    logic [DEPTH-1:0]  q_valid;
    logic              q_is_read [DEPTH];
    logic [31:0]       q_data    [DEPTH];
    logic [3:0]        q_cnt     [DEPTH];

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [3:0]        count;

    logic              data_ok_q;
    logic [31:0]       rdata_q;

    // Size and the address bits outside the word index carry no meaning here.
    logic              unused_bits;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign unused_bits = ^{data_sram.size,
                           data_sram.addr[31:ADDR_W+2],
                           data_sram.addr[1:0]};

    assign word_idx = data_sram.addr[ADDR_W+1:2];

    // The count used here is the pre-pop value, so a slot freed by this
    // cycle's response only becomes available on the following cycle.
    assign data_sram.addr_ok = !reset && !stall_in && (count < DEPTH_CNT);

    assign fire = data_sram.req && data_sram.addr_ok;

    // The head may respond once its countdown has reached zero.
    assign pop = q_valid[rd_ptr] && (q_cnt[rd_ptr] == 4'd0);

    assign data_sram.data_ok = data_ok_q;
    assign data_sram.rdata   = rdata_q;
    assign outstanding       = count;

    // Byte-enabled RAM write at the accepting edge; contents survive reset.
    always_ff @(posedge clk) begin
        if (fire && data_sram.wr) begin
            for (int i = 0; i < 4; i++) begin
                if (data_sram.wstrb[i]) begin
                    mem[word_idx][8*i +: 8] <= data_sram.wdata[8*i +: 8];
                end
            end
        end
    end

    // Pending-response FIFO: countdown, push on accept, pop into the response registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_valid   <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= 4'd0;
            data_ok_q <= 1'b0;
            rdata_q   <= 32'h0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (q_valid[i] && (q_cnt[i] != 4'd0)) begin
                    q_cnt[i] <= q_cnt[i] - 4'd1;
                end
            end

            if (pop) begin
                q_valid[rd_ptr] <= 1'b0;
                rd_ptr          <= next_ptr(rd_ptr);
                data_ok_q       <= 1'b1;
                rdata_q         <= q_is_read[rd_ptr] ? q_data[rd_ptr] : 32'h0;
            end else begin
                data_ok_q       <= 1'b0;
            end

            // A push never targets the popping slot: fire needs a free slot,
            // and the write pointer only meets a valid head when full.
            if (fire) begin
                q_valid[wr_ptr]   <= 1'b1;
                q_is_read[wr_ptr] <= !data_sram.wr;
                q_data[wr_ptr]    <= data_sram.wr ? 32'h0 : mem[word_idx];
                q_cnt[wr_ptr]     <= CNT_INIT;
                wr_ptr            <= next_ptr(wr_ptr);
            end

            case ({fire, pop})
                2'b10:   count <= count + 4'd1;
                2'b01:   count <= count - 4'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_data_sram_responder.sv
// Testbench for data_sram_responder: directed requests push their expected
// response and due cycle into a scoreboard; a negedge monitor pops and checks
// every data_ok, and tracks addr_ok/outstanding against the scoreboard.
module tb_data_sram_responder;

    localparam int LAT   = 2;
    localparam int DEPTH = 2;

    typedef struct {
        logic [31:0] rdata;
        int          fire_edge;
    } sb_entry_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic stall_in = 1'b0;
    logic stall_lat1 = 1'b0;
    logic [3:0] outstanding;
    logic [3:0] outstanding_lat1;

    int cycle = 0;
    int checks = 0;
    int passes = 0;

    sb_entry_t sb[$];

    data_sram_responder_if bus();
    data_sram_responder_if bus1();

    data_sram_responder #(.ADDR_W(12), .LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .data_sram   (bus),
        .stall_in    (stall_in),
        .outstanding (outstanding)
    );

    data_sram_responder #(.ADDR_W(12), .LAT(1), .DEPTH(2)) dut_lat1 (
        .clk         (clk),
        .reset       (reset),
        .data_sram   (bus1),
        .stall_in    (stall_lat1),
        .outstanding (outstanding_lat1)
    );

    always #5 clk = ~clk;

    // Edge counter: after rising edge N, cycle reads N until the next edge.
    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)",
                     name, actual, expected, cycle);
        end
    endtask

    // Holds a request until accepted (bounded), recording its expected response.
    task automatic applyStimulus(input logic wr, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] wstrb,
                                 input logic [31:0] exp_rdata);
        bit accepted = 0;
        bus.req   = 1'b1;
        bus.wr    = wr;
        bus.size  = 2'd2;
        bus.addr  = addr;
        bus.wdata = wdata;
        bus.wstrb = wstrb;
        for (int w = 0; w < 40 && !accepted; w++) begin
            @(negedge clk);
            if (bus.addr_ok === 1'b1) begin
                accepted = 1;
                sb.push_back('{exp_rdata, cycle + 1});
            end
        end
        if (!accepted) checkOutput("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        bus.req = 1'b0;
    endtask

    // Monitor: compare each response and the slot accounting every cycle.
    always @(negedge clk) begin
        int pending;
        sb_entry_t e;
        if (bus.data_ok === 1'b1) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_data_ok", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                checkOutput("data_ok_cycle", cycle, e.fire_edge + LAT);
                checkOutput("rdata", bus.rdata, e.rdata);
            end
        end
        pending = 0;
        foreach (sb[i]) if (sb[i].fire_edge <= cycle) pending++;
        if (cycle >= 1) begin
            checkOutput("addr_ok", {31'd0, bus.addr_ok},
                        {31'd0, (!reset && !stall_in && pending < DEPTH)});
            if (!reset) checkOutput("outstanding", {28'd0, outstanding}, pending);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.req = 1'b0;  bus.wr = 1'b0;  bus.size = 2'd2;
        bus.wstrb = 4'h0; bus.addr = 32'h0; bus.wdata = 32'h0;
        bus1.req = 1'b0; bus1.wr = 1'b0; bus1.size = 2'd2;
        bus1.wstrb = 4'h0; bus1.addr = 32'h0; bus1.wdata = 32'h0;

        $display("[TB] reset");
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_addr_ok", {31'd0, bus.addr_ok}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("reset_data_ok", {31'd0, bus.data_ok}, 32'd0);
        checkOutput("reset_rdata", bus.rdata, 32'h0);
        checkOutput("reset_outstanding", {28'd0, outstanding}, 32'd0);
        @(posedge clk);
        #1;

        $display("[TB] write/read and byte-strobe merge");
        applyStimulus(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0);
        applyStimulus(1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF);
        applyStimulus(1'b1, 32'h0000_0010, 32'h0000_5500, 4'b0010, 32'h0);
        applyStimulus(1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_55EF);

        $display("[TB] back-pressure with req held high");
        applyStimulus(1'b1, 32'h0000_0020, 32'h1111_1111, 4'hF, 32'h0);
        applyStimulus(1'b1, 32'h0000_0024, 32'h2222_2222, 4'hF, 32'h0);
        applyStimulus(1'b1, 32'h0000_0028, 32'h3333_3333, 4'hF, 32'h0);
        applyStimulus(1'b1, 32'h0000_002C, 32'h4444_4444, 4'hF, 32'h0);
        applyStimulus(1'b0, 32'h0000_0020, 32'h0, 4'h0, 32'h1111_1111);
        applyStimulus(1'b0, 32'h0000_0024, 32'h0, 4'h0, 32'h2222_2222);
        applyStimulus(1'b0, 32'h0000_0028, 32'h0, 4'h0, 32'h3333_3333);
        applyStimulus(1'b0, 32'h0000_002C, 32'h0, 4'h0, 32'h4444_4444);

        $display("[TB] stall with a pending read");
        applyStimulus(1'b0, 32'h0000_0020, 32'h0, 4'h0, 32'h1111_1111);
        stall_in = 1'b1;
        bus.req  = 1'b1;
        bus.wr   = 1'b0;
        bus.addr = 32'h0000_0024;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("stall_addr_ok", {31'd0, bus.addr_ok}, 32'd0);
            @(posedge clk);
            #1;
        end
        stall_in = 1'b0;
        applyStimulus(1'b0, 32'h0000_0024, 32'h0, 4'h0, 32'h2222_2222);
        repeat (4) @(posedge clk);
        #1;

        $display("[TB] reset with two pending reads");
        applyStimulus(1'b0, 32'h0000_0020, 32'h0, 4'h0, 32'h1111_1111);
        applyStimulus(1'b0, 32'h0000_0024, 32'h0, 4'h0, 32'h2222_2222);
        reset = 1'b1;
        sb.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        applyStimulus(1'b0, 32'h0000_0010, 32'h0, 4'h0, 32'hDEAD_55EF);

        $display("[TB] address wrap and empty strobe");
        applyStimulus(1'b1, 32'h0000_4014, 32'hCAFE_F00D, 4'hF, 32'h0);
        applyStimulus(1'b0, 32'h0000_0014, 32'h0, 4'h0, 32'hCAFE_F00D);
        applyStimulus(1'b0, 32'h0000_0017, 32'h0, 4'h0, 32'hCAFE_F00D);
        applyStimulus(1'b1, 32'h0000_0014, 32'hFFFF_FFFF, 4'h0, 32'h0);
        applyStimulus(1'b0, 32'h0000_0014, 32'h0, 4'h0, 32'hCAFE_F00D);

        for (int w = 0; w < 50 && sb.size() != 0; w++) @(posedge clk);
        checkOutput("drain_remaining", sb.size(), 32'd0);
        #1;

        $display("[TB] single-cycle latency build");
        bus1.req = 1'b1; bus1.wr = 1'b1; bus1.addr = 32'h0000_0040;
        bus1.wdata = 32'h1234_5678; bus1.wstrb = 4'hF;
        @(negedge clk);
        checkOutput("lat1_addr_ok", {31'd0, bus1.addr_ok}, 32'd1);
        @(posedge clk);
        #1;
        bus1.wr = 1'b0; bus1.wstrb = 4'h0;
        @(negedge clk);
        checkOutput("lat1_no_early_data_ok", {31'd0, bus1.data_ok}, 32'd0);
        checkOutput("lat1_outstanding", {28'd0, outstanding_lat1}, 32'd1);
        @(posedge clk);
        #1 bus1.req = 1'b0;
        @(negedge clk);
        checkOutput("lat1_write_data_ok", {31'd0, bus1.data_ok}, 32'd1);
        checkOutput("lat1_write_rdata", bus1.rdata, 32'h0);
        @(negedge clk);
        checkOutput("lat1_read_data_ok", {31'd0, bus1.data_ok}, 32'd1);
        checkOutput("lat1_read_rdata", bus1.rdata, 32'h1234_5678);
        @(negedge clk);
        checkOutput("lat1_idle_data_ok", {31'd0, bus1.data_ok}, 32'd0);
        checkOutput("lat1_rdata_hold", bus1.rdata, 32'h1234_5678);
        checkOutput("lat1_idle_outstanding", {28'd0, outstanding_lat1}, 32'd0);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
